ram_slot_allocator: RTL

// - Stateful owner of a RAM slot-valid bitmap. Grants the lowest-index free slot per request and retires slots released on

---
 rtl/ram_slot_allocator_pkg.sv | 8 +
 rtl/ram_slot_allocator_first_free_encoder.sv | 31 +++
 rtl/ram_slot_allocator.sv | 77 +++++++
 3 files changed

// File: rtl/ram_slot_allocator_pkg.sv
// ram_slot_allocator_pkg: shared slot-allocator defaults and sizing helpers.
package ram_slot_allocator_pkg;
  localparam int SLOTS_DEF = 32;
  localparam int FREE_PORTS_DEF = 2;
  function automatic int pad_slots(int slot_log);
    return 1 << slot_log;
  endfunction
endpackage

// File: rtl/ram_slot_allocator_first_free_encoder.sv
// ram_slot_allocator_first_free_encoder: log-depth lowest-zero priority encoder over the slot bitmap.
module ram_slot_allocator_first_free_encoder
  import ram_slot_allocator_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int SLOT_LOG = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0]    i_valid,
  output logic [SLOT_LOG-1:0] o_idx,
  output logic                o_any_free
);
  localparam int P = pad_slots(SLOT_LOG);
  logic [P-1:0]        w_pad;
  logic                w_any [2*P-1];
  logic [SLOT_LOG-1:0] w_idx [2*P-1];
  // Heap-ordered binary tree: leaves at P-1.., each node prefers its left (lower) child.
  always_comb begin
    w_pad = '1;
    w_pad[SLOTS-1:0] = i_valid;
    for (int n = 0; n < P; n++) begin
      w_any[P-1+n] = ~w_pad[n];
      w_idx[P-1+n] = SLOT_LOG'(n);
    end
    for (int n = P - 2; n >= 0; n--) begin
      w_any[n] = w_any[2*n+1] | w_any[2*n+2];
      w_idx[n] = w_any[2*n+1] ? w_idx[2*n+1] : w_idx[2*n+2];
    end
  end
  assign o_idx = w_idx[0];
  assign o_any_free = w_any[0];
endmodule

// File: rtl/ram_slot_allocator.sv
// ram_slot_allocator: owns the slot-valid bitmap, grants lowest free slot, retires multi-port releases.
module ram_slot_allocator
  import ram_slot_allocator_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int SLOT_LOG = $clog2(SLOTS),
  parameter int FREE_PORTS = FREE_PORTS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_flush,
  input  logic                           i_alloc_req,
  output logic                           o_alloc_gnt,
  output logic [SLOT_LOG-1:0]            o_alloc_idx,
  input  logic [FREE_PORTS-1:0]          i_free_vld,
  input  logic [FREE_PORTS*SLOT_LOG-1:0] i_free_idx,
  output logic [SLOTS-1:0]               o_valid,
  output logic [SLOT_LOG:0]              o_count,
  output logic                           o_full,
  output logic                           o_empty,
  output logic                           o_free_err
);
  logic [SLOTS-1:0]    r_valid, w_clr, w_set;
  logic [SLOT_LOG:0]   r_count, w_nfree;
  logic [SLOT_LOG-1:0] r_idx, w_idx, w_fidx;
  logic                r_gnt, r_err, w_err, w_any_free, w_grant;
  ram_slot_allocator_first_free_encoder #(.SLOTS(SLOTS), .SLOT_LOG(SLOT_LOG)) u_ffe (
    .i_valid(r_valid),
    .o_idx(w_idx),
    .o_any_free(w_any_free)
  );
  // Duplicate frees of one index collapse in the OR mask, so w_nfree counts distinct slots.
  always_comb begin
    w_clr = '0;
    w_err = 1'b0;
    w_fidx = '0;
    w_nfree = '0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      w_fidx = i_free_idx[p*SLOT_LOG +: SLOT_LOG];
      if (i_free_vld[p]) begin
        if ({1'b0, w_fidx} < (SLOT_LOG+1)'(SLOTS) && r_valid[w_fidx]) w_clr[w_fidx] = 1'b1;
        else w_err = 1'b1;
      end
    end
    for (int i = 0; i < SLOTS; i++) w_nfree = w_nfree + (SLOT_LOG+1)'(w_clr[i]);
  end
  assign w_grant = i_alloc_req & w_any_free;
  assign w_set = w_grant ? SLOTS'(1) << w_idx : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
      r_gnt <= 1'b0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else if (i_flush) begin
      r_valid <= '0;
      r_count <= '0;
      r_gnt <= 1'b0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      r_valid <= (r_valid & ~w_clr) | w_set;
      r_count <= r_count + (SLOT_LOG+1)'(w_grant) - w_nfree;
      r_gnt <= w_grant;
      r_idx <= w_grant ? w_idx : '0;
      r_err <= r_err | w_err;
    end
  end
  assign o_valid = r_valid;
  assign o_count = r_count;
  assign o_alloc_gnt = r_gnt;
  assign o_alloc_idx = r_idx;
  assign o_free_err = r_err;
  assign o_full = r_count == (SLOT_LOG+1)'(SLOTS);
  assign o_empty = r_count == '0;
endmodule
